// File: rtl/xpe_out_proc_if.sv
// Beat bus between the XPE accumulator array and the output post-processor.
// The slave side consumes accumulator beats and produces quantized 8-bit beats.
interface xpe_out_proc_if;
  logic [511:0] acc_dat;
  logic         acc_vld;
  logic [255:0] dat;
  logic         vld;
  logic         sat;

  modport master (
    output acc_dat,
    output acc_vld,
    input  dat,
    input  vld,
    input  sat
  );

  modport slave (
    input  acc_dat,
    input  acc_vld,
    output dat,
    output vld,
    output sat
  );
endinterface

// File: rtl/xpe_out_proc.sv
// XPE output post-processor: per-lane round/shift/saturate to int8, optional 2:1 max pooling.
// Optional ReLU after saturation is compiled in with macro XPE_OUT_PROC_RELU_EN.
module xpe_out_proc (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_calculate_enable,
  input  logic [3:0]    i_shift,
  input  logic          i_pool_en,
  input  logic [7:0]    i_x_length,
  xpe_out_proc_if.slave xpe
);

  logic [3:0]   r_shift;
  logic         r_pool_en;
  logic [7:0]   r_x_len;
  logic [255:0] r_s1_dat;
  logic         r_s1_vld;
  logic         r_sat;
  logic [7:0]   r_x_cnt;
  logic         r_pair;
  logic [255:0] r_hold;
  logic [255:0] r_dat;
  logic         r_vld;

  logic [255:0] w_q_dat;
  logic [31:0]  w_clip;
  logic [255:0] w_max;
  logic         w_last;

  // Returns {clipped, int8}; rounding term is at most 2^14, so 17 bits never overflow.
  function automatic logic [8:0] quantize(input logic [15:0] acc, input logic [3:0] sh);
    logic signed [16:0] ext;
    logic signed [16:0] rnd;
    logic signed [16:0] sum;
    logic signed [16:0] shr;
    logic [8:0]         res;
    ext = {acc[15], acc};
    if (sh != 4'd0) begin
      rnd = 17'sd1 <<< (sh - 4'd1);
    end else begin
      rnd = 17'sd0;
    end
    sum = ext + rnd;
    shr = sum >>> sh;
    if (shr > 17'sd127) begin
      res = {1'b1, 8'h7F};
    end else if (shr < -17'sd128) begin
      res = {1'b1, 8'h80};
    end else begin
      res = {1'b0, shr[7:0]};
    end
`ifdef XPE_OUT_PROC_RELU_EN
    if (res[7]) begin
      res[7:0] = 8'h00;
    end else begin
      res[7:0] = res[7:0];
    end
`endif
    return res;
  endfunction

  always_comb begin
    logic [8:0] v_q;
    w_q_dat = 256'd0;
    w_clip  = 32'd0;
    w_max   = 256'd0;
    v_q     = 9'd0;
    for (int k = 0; k < 32; k++) begin
      v_q                = quantize(xpe.acc_dat[16*k +: 16], r_shift);
      w_q_dat[8*k +: 8]  = v_q[7:0];
      w_clip[k]          = v_q[8];
      if ($signed(r_hold[8*k +: 8]) > $signed(r_s1_dat[8*k +: 8])) begin
        w_max[8*k +: 8] = r_hold[8*k +: 8];
      end else begin
        w_max[8*k +: 8] = r_s1_dat[8*k +: 8];
      end
    end
  end

  // A latched length of 0 means 256, so length-1 wraps naturally to 255.
  assign w_last = (r_x_cnt == (r_x_len - 8'd1));

  // Configuration latch and stage 1 (quantize).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= 4'd0;
      r_pool_en <= 1'b0;
      r_x_len   <= 8'd0;
      r_s1_dat  <= 256'd0;
      r_s1_vld  <= 1'b0;
      r_sat     <= 1'b0;
    end else if (i_calculate_enable) begin
      r_shift   <= i_shift;
      r_pool_en <= i_pool_en;
      r_x_len   <= i_x_length;
      r_s1_vld  <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_s1_vld <= xpe.acc_vld;
      if (xpe.acc_vld) begin
        r_s1_dat <= w_q_dat;
        if (|w_clip) begin
          r_sat <= 1'b1;
        end
      end
    end
  end

  // Stage 2: passthrough or row-bounded 2:1 max pooling.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x_cnt <= 8'd0;
      r_pair  <= 1'b0;
      r_hold  <= 256'd0;
      r_dat   <= 256'd0;
      r_vld   <= 1'b0;
    end else if (i_calculate_enable) begin
      r_x_cnt <= 8'd0;
      r_pair  <= 1'b0;
      r_hold  <= 256'd0;
      r_vld   <= 1'b0;
    end else if (r_s1_vld) begin
      r_x_cnt <= w_last ? 8'd0 : (r_x_cnt + 8'd1);
      if (!r_pool_en) begin
        r_dat <= r_s1_dat;
        r_vld <= 1'b1;
      end else if (r_pair) begin
        r_dat  <= w_max;
        r_vld  <= 1'b1;
        r_pair <= 1'b0;
      end else if (w_last) begin
        r_dat  <= r_s1_dat;
        r_vld  <= 1'b1;
        r_pair <= 1'b0;
      end else begin
        r_hold <= r_s1_dat;
        r_pair <= 1'b1;
        r_vld  <= 1'b0;
      end
    end else begin
      r_vld <= 1'b0;
    end
  end

  assign xpe.dat = r_dat;
  assign xpe.vld = r_vld;
  assign xpe.sat = r_sat;

endmodule

// File: tb/tb_xpe_out_proc.sv
// Directed + randomized bench for xpe_out_proc with an output scoreboard.
module tb_xpe_out_proc;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_calculate_enable;
  logic [3:0] i_shift;
  logic       i_pool_en;
  logic [7:0] i_x_length;

  xpe_out_proc_if bus ();

  xpe_out_proc dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_calculate_enable (i_calculate_enable),
    .i_shift            (i_shift),
    .i_pool_en          (i_pool_en),
    .i_x_length         (i_x_length),
    .xpe                (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  logic [255:0] sb[$];

  int           m_shift;
  bit           m_pool;
  int           m_xlen;
  int           m_x;
  bit           m_pair;
  logic [255:0] m_hold;
  bit           m_sat;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference quantizer on plain integers.
  function automatic logic [7:0] q8(input logic [15:0] a, input int s, output bit clip);
    int v;
    v    = $signed(a);
    clip = 1'b0;
    if (s > 0) v = v + (1 << (s - 1));
    v = v >>> s;
    if (v > 127) begin v = 127; clip = 1'b1; end
    if (v < -128) begin v = -128; clip = 1'b1; end
`ifdef XPE_OUT_PROC_RELU_EN
    if (v < 0) v = 0;
`endif
    return v[7:0];
  endfunction

  function automatic logic [255:0] qbeat(input logic [511:0] d, input int s, output bit clip);
    logic [255:0] r;
    bit c;
    clip = 1'b0;
    for (int k = 0; k < 32; k++) begin
      r[8*k +: 8] = q8(d[16*k +: 16], s, c);
      if (c) clip = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [255:0] pmax(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    for (int k = 0; k < 32; k++)
      r[8*k +: 8] = ($signed(a[8*k +: 8]) > $signed(b[8*k +: 8])) ? a[8*k +: 8] : b[8*k +: 8];
    return r;
  endfunction

  function automatic logic [511:0] mk(input logic [15:0] l0, input logic [15:0] l1,
                                      input logic [15:0] l2, input logic [15:0] l3,
                                      input logic [15:0] l31);
    logic [511:0] d;
    d = 512'd0;
    d[15:0] = l0; d[31:16] = l1; d[47:32] = l2; d[63:48] = l3; d[511:496] = l31;
    return d;
  endfunction

  function automatic logic [511:0] rand_beat();
    logic [511:0] d;
    logic [31:0]  r;
    for (int k = 0; k < 32; k++) begin
      r = $urandom;
      d[16*k +: 16] = r[15:0];
    end
    return d;
  endfunction

  task automatic model_push(input logic [255:0] q);
    bit last;
    last = (m_x == m_xlen - 1);
    if (!m_pool) sb.push_back(q);
    else if (m_pair) begin sb.push_back(pmax(m_hold, q)); m_pair = 1'b0; end
    else if (last) sb.push_back(q);
    else begin m_hold = q; m_pair = 1'b1; end
    m_x = last ? 0 : m_x + 1;
  endtask

  task automatic beat(input logic [511:0] d);
    logic [255:0] q;
    bit c;
    bus.acc_dat = d;
    bus.acc_vld = 1'b1;
    q = qbeat(d, m_shift, c);
    if (c) m_sat = 1'b1;
    model_push(q);
    @(negedge i_clk);
    bus.acc_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic start(input logic [3:0] s, input bit p, input logic [7:0] xl,
                       input bit with_beat, input logic [511:0] d);
    check("sb_empty_at_start", 256'(sb.size()), 256'd0);
    i_shift = s; i_pool_en = p; i_x_length = xl; i_calculate_enable = 1'b1;
    if (with_beat) begin bus.acc_dat = d; bus.acc_vld = 1'b1; end
    m_shift = s; m_pool = p; m_xlen = (xl == 8'd0) ? 256 : xl;
    m_x = 0; m_pair = 1'b0; m_sat = 1'b0;
    @(negedge i_clk);
    i_calculate_enable = 1'b0;
    bus.acc_vld = 1'b0;
  endtask

  // Scoreboard: every output beat must match the oldest pending expectation.
  always @(negedge i_clk) begin
    if (bus.vld) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_vld observed=%h expected=none", bus.dat);
      end
      if (sb.size() != 0) check("sb_dat", bus.dat, sb.pop_front());
    end
  end

  initial begin
    i_rst_n = 1'b0; i_calculate_enable = 1'b0; i_shift = 4'd0; i_pool_en = 1'b0;
    i_x_length = 8'd0; bus.acc_dat = 512'd0; bus.acc_vld = 1'b0;
    m_shift = 0; m_pool = 1'b0; m_xlen = 256; m_x = 0; m_pair = 1'b0; m_hold = 256'd0; m_sat = 1'b0;
    idle(3);
    check("rst_dat", bus.dat, 256'd0);
    check("rst_vld", 256'(bus.vld), 256'd0);
    check("rst_sat", 256'(bus.sat), 256'd0);
    i_rst_n = 1'b1;
    idle(2);

    // Passthrough and two-edge latency
    start(4'd0, 1'b0, 8'd0, 1'b0, 512'd0);
    beat(mk(16'd100, 16'd0, 16'd0, 16'd0, 16'hFFCE));
    check("pt_lat_early", 256'(bus.vld), 256'd0);
    idle(1);
    check("pt_lat_vld", 256'(bus.vld), 256'd1);
    check("pt_lane0", 256'(bus.dat[7:0]), 256'(8'd100));
    check("pt_lane31", 256'(bus.dat[255:248]), 256'(8'hCE));
    idle(2);
    check("pt_sat", 256'(bus.sat), 256'd0);
    check("pt_hold_dat", 256'(bus.dat[7:0]), 256'(8'd100));

    // ReLU / signed passthrough of -5
    beat(mk(16'hFFFB, 16'd0, 16'd0, 16'd0, 16'd0));
    idle(1);
`ifdef XPE_OUT_PROC_RELU_EN
    check("relu_lane0", 256'(bus.dat[7:0]), 256'(8'h00));
`else
    check("relu_lane0", 256'(bus.dat[7:0]), 256'(8'hFB));
`endif
    idle(2);

    // Round, shift, saturate
    start(4'd4, 1'b0, 8'd0, 1'b0, 512'd0);
    beat(mk(16'h0018, 16'h0017, 16'h7FFF, 16'h8000, 16'd0));
    idle(1);
`ifdef XPE_OUT_PROC_RELU_EN
    check("rss_lanes", 256'(bus.dat[31:0]), 256'(32'h007F0102));
`else
    check("rss_lanes", 256'(bus.dat[31:0]), 256'(32'h807F0102));
`endif
    check("rss_sat", 256'(bus.sat), 256'd1);
    for (int i = 0; i < 6; i++) beat(rand_beat());
    beat(mk(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    idle(3);
    check("rss_sat_sticky", 256'(bus.sat), 256'd1);

    // Pooling, odd row length 5
    start(4'd0, 1'b1, 8'd5, 1'b0, 512'd0);
    beat(mk(16'd3, 16'd0, 16'd0, 16'd0, 16'd0));
    beat(mk(16'd9, 16'd0, 16'd0, 16'd0, 16'd0));
    beat(mk(16'hFFFE, 16'd0, 16'd0, 16'd0, 16'd0));
    beat(mk(16'hFFF9, 16'd0, 16'd0, 16'd0, 16'd0));
    beat(mk(16'd4, 16'd0, 16'd0, 16'd0, 16'd0));
`ifdef XPE_OUT_PROC_RELU_EN
    check("pool_pair2", 256'(bus.dat[7:0]), 256'(8'h00));
`else
    check("pool_pair2", 256'(bus.dat[7:0]), 256'(8'hFE));
`endif
    idle(1);
    check("pool_odd_vld", 256'(bus.vld), 256'd1);
    check("pool_odd_dat", 256'(bus.dat[7:0]), 256'(8'd4));
    idle(3);

    // Pooling with random bubbles, then gap-free, across several rows
    start(4'd3, 1'b1, 8'd7, 1'b0, 512'd0);
    for (int i = 0; i < 16; i++) begin
      beat(rand_beat());
      idle($urandom_range(0, 3));
    end
    idle(4);
    start(4'd3, 1'b1, 8'd7, 1'b0, 512'd0);
    for (int i = 0; i < 16; i++) beat(rand_beat());
    idle(4);

    // Restart mid-pair with a beat in the start cycle
    start(4'd0, 1'b1, 8'd4, 1'b0, 512'd0);
    beat(mk(16'd1000, 16'd0, 16'd0, 16'd0, 16'd0));
    idle(2);
    check("rs_sat_set", 256'(bus.sat), 256'd1);
    start(4'd2, 1'b1, 8'd4, 1'b1, mk(16'h7FFF, 16'd0, 16'd0, 16'd0, 16'd0));
    check("rs_sat_clr", 256'(bus.sat), 256'd0);
    idle(3);
    check("rs_dropped_sat", 256'(bus.sat), 256'd0);
    check("rs_no_stale", 256'(bus.vld), 256'd0);
    beat(mk(16'd20, 16'd0, 16'd0, 16'd0, 16'd0));
    beat(mk(16'd41, 16'd0, 16'd0, 16'd0, 16'd0));
    idle(1);
    check("rs_new_cfg", 256'(bus.dat[7:0]), 256'(8'd10));
    idle(3);

    check("sb_drained", 256'(sb.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xpe_out_proc.md
# xpe_out_proc

Post-processing stage between the XPE array and OAGU. Takes 32 lanes of signed 16-bit accumulator results per beat, then rounds, shifts and saturates each lane to signed 8-bit. It optionally applies ReLU and horizontal 2:1 max pooling. It presents 256-bit beats with a valid strobe that connect directly to OAGU's `i_xpe_dat_out`/`i_xpe_dat_vld`.

## Interface
Parameters: none. Lane count (32), accumulator width (16), output width (8) are fixed.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_calculate_enable  in  1  single-cycle start pulse. Latches configuration, clears counters, flushes the pipeline.
- i_shift  in  4  right-shift amount, 0–15. Latched on start.
- i_pool_en  in  1  enables 2:1 horizontal max pooling. Latched on start.
- i_x_length  in  8  input pixels per row. 0 means 256. Latched on start.
- i_acc_dat  in  512  lane k is bits [16k+15:16k], signed.
- i_acc_vld  in  1  beat valid. No backpressure.
- o_dat  out  256  lane k is bits [8k+7:8k], signed.
- o_vld  out  1  output beat valid.
- o_sat  out  1  sticky flag: any lane saturated since the last start.

## Operation
Stage 1 (quantize), registered on `i_acc_vld`, applied per lane:
- Sign-extend the accumulator to 17 bits.
- If the latched shift s > 0, add 2^(s-1) (round half up). This cannot overflow 17 bits.
- Arithmetic right shift by s.
- Saturate to [-128, 127]. Any lane clipping sets o_sat.
- With RELU compiled in, negative results become 0 after saturation.
- Results go to s1_dat; s1_vld <= i_acc_vld.

Stage 2 (pool/output):
- Pooling off: o_dat <= s1_dat, o_vld <= s1_vld.
- Pooling on: an 8-bit x counter counts s1 beats and wraps at x_length. A pair flag toggles per beat.
  - First beat of a pair is stored in a hold register. No output.
  - Second beat: o_dat <= per-lane signed max(hold, s1_dat), o_vld = 1.
  - Last beat of a row that is the first of a pair (odd x_length): o_dat <= s1_dat, o_vld = 1, and the pair flag resets.
  - Pairing never crosses a row boundary.
- The x counter and pair flag advance only on s1_vld.
- OAGU must be programmed with output row length ceil(x_length/2) when pooling is on.

Start pulse:
- Takes priority over everything.
- Latches i_shift, i_pool_en and i_x_length.
- Clears the x counter, pair flag, hold register and o_sat.
- Forces s1_vld = 0 and o_vld = 0 on the following edge.
- An `i_acc_vld` beat in the same cycle as the start pulse is dropped.
- Config inputs are ignored between starts.

## Timing
- Reset values: o_dat = 0, o_vld = 0, o_sat = 0. Internal registers are also 0, latched x_length is 256, shift is 0.
- Latency, pooling off: input beat at edge N produces o_vld at edge N+2. Sustained one beat per cycle.
- Latency, pooling on: o_vld is asserted 2 edges after the second (or odd final) beat of the pair. Maximum rate is one output per two inputs.
- o_dat holds its last value while o_vld = 0.
- o_sat goes high on the edge that registers the saturating stage-1 result.
- Bubbles in `i_acc_vld` at any position, including mid-pair, are tolerated. The hold register is kept.
- Asynchronous reset mid-row discards all in-flight beats.

## Configuration
- Macro `XPE_OUT_PROC_RELU_EN`.
- Defined: ReLU is applied after saturation in stage 1. Output lanes are always ≥ 0, and o_sat still reports negative clipping.
- Undefined: signed outputs pass through unchanged.
- Latency is identical in both builds.

## Test plan
- Passthrough: shift 0, pool off, lane 0 = 100, lane 31 = -50 → o_vld 2 cycles later with lanes 100 and -50; o_sat = 0.
- Round/shift/saturate: shift 4, lanes 0x0018, 0x0017, 0x7FFF, 0x8000 → 2, 1, 127, -128; o_sat = 1 and stays set until the next start.
- ReLU build: shift 0, lane = -5 → 0 with the macro defined, 0xFB without.
- Pooling, x_length 5: beats with lane 0 = 3, 9, -2, -7, 4 → three outputs: 9, -2, 4; the third appears 2 cycles after the fifth input.
- Bubbles: pool on, gaps of 0–3 idle cycles inserted randomly between beats → output sequence identical to the gap-free run; exactly one o_vld per pair.
- Restart: start pulse after the first beat of a pair, with `i_acc_vld` high in the same cycle → that beat is dropped, no stale output, o_sat cleared, and the next pair uses the newly latched configuration.
